stream_tx_shell: RTL and testbench
==================================

// Module: stream_tx_shell
// PURPOSE
//  Transmit-side shell between an operator's output port and the write side of a stream_shell FIFO.
//  Buffers operator output in a small synchronous queue and issues writes only when the downstream
//  FIFO reports not-full. The downstream FIFO writes on every cycle with val_in=1 and does not check
//  for full, so this block must never assert val_out while ready_downward=0.
//  Provides per-port performance counters for bottleneck analysis.
// PARAMETERS
//  PAYLOAD_BITS   128  data width, both sides
//  NUM_ADDR_BITS  3    local queue depth = 2**NUM_ADDR_BITS (default 8 entries)
// PORTS
//  clk              in   1             single clock: operator and FIFO write side
//  reset_n          in   1             asynchronous, active-low reset
//  din              in   PAYLOAD_BITS  operator output data
//  val_in           in   1             operator data valid
//  ready_upward     out  1             queue can accept data (= ~full)
//  dout             out  PAYLOAD_BITS  data to stream_shell din
//  val_out          out  1             write strobe to stream_shell val_in
//  ready_downward   in   1             stream_shell ready_upward (~full of async FIFO)
//  reset_ap_start   in   1             synchronous clear of all counters
//  state            in   1             1 = counters frozen (operator idle/config)
//  full_cnt         out  32            cycles with local queue full
//  stall_cnt        out  32            cycles with data pending but ready_downward=0
//  write_cnt        out  32            words delivered downstream
//  fill_level       out  NUM_ADDR_BITS+1  current queue occupancy, 0..DEPTH
// BEHAVIOUR
//  Storage
//   - Register array mem[DEPTH].
//   - wr_ptr and rd_ptr are NUM_ADDR_BITS+1 bits wide.
//   - Index with the low bits; the MSB distinguishes full from empty.
//     Pointers wrap naturally at 2**(NUM_ADDR_BITS+1).
//   - full  = (ptr MSBs differ and low bits equal); empty = (wr_ptr == rd_ptr).
//   - fill_level = wr_ptr - rd_ptr, modulo 2**(NUM_ADDR_BITS+1).
//  Push
//   - push = val_in & ready_upward.
//   - ready_upward = ~full, derived from registered pointers only.
//   - A pop in the same cycle does NOT raise ready_upward; no pass-through when full.
//   - val_in while full is ignored: no write, pointers unchanged.
//  Pop
//   - val_out = ~empty & ready_downward (combinational).
//   - pop = val_out; every cycle with val_out=1 is exactly one transfer.
//   - dout = empty ? 0 : mem[rd_ptr]. When full-but-stalled, dout is held stable.
//  Timing and ordering
//   - Latency: a word pushed in cycle N is visible on dout/val_out in cycle N+1 at the earliest.
//     There is no same-cycle bypass.
//   - Simultaneous push and pop when neither full nor empty: both pointers advance; occupancy unchanged.
//   - Order is strictly FIFO. No data is lost or duplicated.
//  Counters (each increments only while state=0)
//   - full_cnt:  +1 per cycle with full=1.
//   - stall_cnt: +1 per cycle with ~empty & ~ready_downward.
//   - write_cnt: +1 per pop.
//   - reset_ap_start=1 clears all three synchronously; it has priority over increment.
//   - All counters wrap modulo 2**32.
//  Reset
//   - reset_n=0 asynchronously clears wr_ptr, rd_ptr and all counters.
//   - Outputs during reset: val_out=0, dout=0, ready_upward=1, fill_level=0.
//   - Reset mid-stream discards queued data; mem contents need no reset.
// TESTING
//  1. Reset, then 5 pushes with ready_downward=1:
//     -> val_out rises 1 cycle after the first push; dout = d0..d4 in order; write_cnt=5.
//  2. ready_downward=0, val_in=1 for 10 cycles:
//     -> ready_upward drops after 8 accepts; fill_level=8; val_out stays 0; full_cnt counts 2.
//  3. From full, raise ready_downward for 1 cycle with val_in=1:
//     -> exactly 1 pop, no push that cycle; fill_level=7; dout advances to the next word.
//  4. Continuous push/pop at steady state with ready_downward toggling 1,0,1,0:
//     -> no loss or duplication over 100 words; stall_cnt = number of ready_downward=0 cycles
//        with data pending.
//  5. state=1 during traffic, then reset_ap_start pulse:
//     -> counters frozen while state=1; all read 0 the cycle after the pulse.
//  6. Assert reset_n=0 with 4 words queued, between clock edges:
//     -> val_out=0, fill_level=0, ready_upward=1 immediately; after release, the first pushed
//        word is the next dout.

Source files
------------

// File: rtl/stream_tx_shell_if.sv
// ============================================================================
// Module      : stream_tx_shell_if
// Description : Operator-side and FIFO-side handshake bundle for the TX shell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stream_tx_shell_if #(
    parameter int PAYLOAD_BITS = 128
);
    logic [PAYLOAD_BITS-1:0] din;
    logic                    val_in;
    logic                    ready_upward;
    logic [PAYLOAD_BITS-1:0] dout;
    logic                    val_out;
    logic                    ready_downward;

    // The shell itself
    modport master (
        input  din,
        input  val_in,
        output ready_upward,
        output dout,
        output val_out,
        input  ready_downward
    );

    // The operator and downstream FIFO around the shell
    modport slave (
        output din,
        output val_in,
        input  ready_upward,
        input  dout,
        input  val_out,
        output ready_downward
    );
endinterface

`default_nettype wire

// File: rtl/stream_tx_shell.sv
// ============================================================================
// Module      : stream_tx_shell
// Description : Small FIFO between operator output and a stream_shell write
//               port, with full/stall/write performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_tx_shell #(
    parameter int PAYLOAD_BITS  = 128,
    parameter int NUM_ADDR_BITS = 3
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    stream_tx_shell_if.master             bus,
    input  wire logic                     reset_ap_start,
    input  wire logic                     state,
    output logic [31:0]                   full_cnt,
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   write_cnt,
    output logic [NUM_ADDR_BITS:0]        fill_level
);

    localparam int c_DEPTH = 2 ** NUM_ADDR_BITS;

    logic [PAYLOAD_BITS-1:0]  r_mem [c_DEPTH];
    logic [NUM_ADDR_BITS:0]   r_wr_ptr;
    logic [NUM_ADDR_BITS:0]   r_rd_ptr;
    logic [31:0]              r_full_cnt;
    logic [31:0]              r_stall_cnt;
    logic [31:0]              r_write_cnt;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic [NUM_ADDR_BITS-1:0] w_wr_idx;
    logic [NUM_ADDR_BITS-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[NUM_ADDR_BITS-1:0];
    assign w_rd_idx = r_rd_ptr[NUM_ADDR_BITS-1:0];
    assign w_full   = (r_wr_ptr[NUM_ADDR_BITS] != r_rd_ptr[NUM_ADDR_BITS]) &&
                      (w_wr_idx == w_rd_idx);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);

    // Downstream FIFO never checks full, so val_out must be gated by ready_downward
    assign w_push   = bus.val_in & ~w_full;
    assign w_pop    = ~w_empty & bus.ready_downward;

    assign bus.ready_upward = ~w_full;
    assign bus.val_out      = w_pop;
    assign bus.dout         = w_empty ? '0 : r_mem[w_rd_idx];
    assign fill_level       = r_wr_ptr - r_rd_ptr;

    assign full_cnt  = r_full_cnt;
    assign stall_cnt = r_stall_cnt;
    assign write_cnt = r_write_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full_cnt  <= '0;
            r_stall_cnt <= '0;
            r_write_cnt <= '0;
        end else if (reset_ap_start) begin
            r_full_cnt  <= '0;
            r_stall_cnt <= '0;
            r_write_cnt <= '0;
        end else if (!state) begin
            if (w_full) begin
                r_full_cnt <= r_full_cnt + 32'd1;
            end
            if (!w_empty && !bus.ready_downward) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_pop) begin
                r_write_cnt <= r_write_cnt + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_tx_shell.sv
// ============================================================================
// Module      : tb_stream_tx_shell
// Description : Directed plus randomized bench for stream_tx_shell against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_tx_shell;

    localparam int c_W     = 128;
    localparam int c_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reset_ap_start;
    logic        state;
    logic [31:0] full_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] write_cnt;
    logic [3:0]  fill_level;

    int total = 0;
    int bad   = 0;

    // Reference model: queue contents and counter values
    logic [c_W-1:0] mq[$];
    logic [31:0]    m_full;
    logic [31:0]    m_stall;
    logic [31:0]    m_write;

    stream_tx_shell_if #(.PAYLOAD_BITS(c_W)) bus ();

    stream_tx_shell #(
        .PAYLOAD_BITS  (c_W),
        .NUM_ADDR_BITS (3)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .reset_ap_start (reset_ap_start),
        .state          (state),
        .full_cnt       (full_cnt),
        .stall_cnt      (stall_cnt),
        .write_cnt      (write_cnt),
        .fill_level     (fill_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Compare all outputs against the model mid-cycle, then advance one clock
    task automatic step();
        int             sz;
        bit             push;
        bit             pop;
        logic [c_W-1:0] d;
        #4;
        sz = mq.size();
        check("ready_upward", c_W'(bus.ready_upward), c_W'(sz < c_DEPTH));
        check("val_out", c_W'(bus.val_out), c_W'(sz > 0 && bus.ready_downward));
        check("dout", bus.dout, (sz > 0) ? mq[0] : '0);
        check("fill_level", c_W'(fill_level), c_W'(sz));
        check("full_cnt", c_W'(full_cnt), c_W'(m_full));
        check("stall_cnt", c_W'(stall_cnt), c_W'(m_stall));
        check("write_cnt", c_W'(write_cnt), c_W'(m_write));
        push = bus.val_in && (sz < c_DEPTH);
        pop  = (sz > 0) && bus.ready_downward;
        d    = bus.din;
        if (reset_ap_start) begin
            m_full = 0; m_stall = 0; m_write = 0;
        end else if (!state) begin
            if (sz == c_DEPTH)               m_full  = m_full + 1;
            if (sz > 0 && !bus.ready_downward) m_stall = m_stall + 1;
            if (pop)                         m_write = m_write + 1;
        end
        @(posedge clk);
        #1;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(d);
    endtask

    initial begin
        logic [31:0] f0, s0, w0;
        reset_n            = 1'b0;
        reset_ap_start     = 1'b0;
        state              = 1'b0;
        bus.din            = '0;
        bus.val_in         = 1'b0;
        bus.ready_downward = 1'b0;
        m_full = 0; m_stall = 0; m_write = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_val_out", c_W'(bus.val_out), c_W'(0));
        check("rst_dout", bus.dout, '0);
        check("rst_ready_upward", c_W'(bus.ready_upward), c_W'(1));
        check("rst_fill", c_W'(fill_level), c_W'(0));
        reset_n = 1'b1;

        // 1: five pushes straight through
        bus.ready_downward = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.val_in = 1'b1; bus.din = rand_word();
            step();
        end
        bus.val_in = 1'b0;
        repeat (6) step();
        check("t1_write_cnt", c_W'(write_cnt), c_W'(5));

        // 2: fill with downstream blocked
        bus.ready_downward = 1'b0;
        f0 = full_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.val_in = 1'b1; bus.din = rand_word();
            step();
        end
        check("t2_fill", c_W'(fill_level), c_W'(8));
        check("t2_ready_upward", c_W'(bus.ready_upward), c_W'(0));
        check("t2_full_delta", c_W'(full_cnt - f0), c_W'(2));

        // 3: single pop from full, push attempt is refused
        bus.ready_downward = 1'b1; bus.din = rand_word();
        step();
        bus.ready_downward = 1'b0; bus.val_in = 1'b0;
        check("t3_fill", c_W'(fill_level), c_W'(7));
        step();

        // 4: continuous traffic with toggling ready_downward
        for (int i = 0; i < 220; i++) begin
            bus.val_in = 1'b1; bus.din = rand_word();
            bus.ready_downward = (i % 2 == 0);
            step();
        end
        bus.val_in = 1'b0; bus.ready_downward = 1'b1;
        repeat (10) step();

        // 5: frozen counters, then synchronous clear
        state = 1'b1;
        f0 = full_cnt; s0 = stall_cnt; w0 = write_cnt;
        for (int i = 0; i < 20; i++) begin
            bus.val_in = $urandom_range(0, 1); bus.din = rand_word();
            bus.ready_downward = $urandom_range(0, 1);
            step();
        end
        check("t5_full_frozen", c_W'(full_cnt), c_W'(f0));
        check("t5_stall_frozen", c_W'(stall_cnt), c_W'(s0));
        check("t5_write_frozen", c_W'(write_cnt), c_W'(w0));
        state = 1'b0; reset_ap_start = 1'b1; bus.val_in = 1'b0;
        step();
        reset_ap_start = 1'b0;
        check("t5_full_clr", c_W'(full_cnt), c_W'(0));
        check("t5_stall_clr", c_W'(stall_cnt), c_W'(0));
        check("t5_write_clr", c_W'(write_cnt), c_W'(0));

        // 6: asynchronous reset with four words queued
        bus.ready_downward = 1'b1;
        repeat (10) step();
        bus.ready_downward = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.val_in = 1'b1; bus.din = rand_word();
            step();
        end
        bus.val_in = 1'b0; bus.ready_downward = 1'b1;
        #1;
        check("t6_pre_val_out", c_W'(bus.val_out), c_W'(1));
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_val_out", c_W'(bus.val_out), c_W'(0));
        check("t6_fill", c_W'(fill_level), c_W'(0));
        check("t6_ready_upward", c_W'(bus.ready_upward), c_W'(1));
        check("t6_dout", bus.dout, '0);
        mq.delete();
        m_full = 0; m_stall = 0; m_write = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.val_in = 1'b1; bus.din = rand_word();
        step();
        bus.val_in = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.val_in         = $urandom_range(0, 1);
            bus.din            = rand_word();
            bus.ready_downward = ($urandom_range(0, 3) != 0);
            state              = ($urandom_range(0, 15) == 0);
            reset_ap_start     = ($urandom_range(0, 63) == 0);
            step();
        end
        state = 1'b0; reset_ap_start = 1'b0; bus.val_in = 1'b0; bus.ready_downward = 1'b1;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
